// File: rtl/sap1_control_sequencer_if.sv
// +------------------------------------------------------------------+
// | Module   : sap1_control_sequencer_if                             |
// | Purpose  : Control-bus bundle between the SAP-1 sequencer and    |
// |            its datapath: clock enable, opcode, flags, step       |
// |            number and all load/output-enable lines.              |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
`default_nettype none

interface sap1_control_sequencer_if;
  logic       mclk_en;
  logic [3:0] i_opcode;
  logic       i_flag_carry;
  logic       i_flag_zero;
  logic [2:0] o_step;
  logic       o_pc_out;
  logic       o_pc_inc;
  logic       o_pc_load;
  logic       o_mar_load;
  logic       o_ram_out;
  logic       o_ram_load;
  logic       o_ir_load;
  logic       o_ir_out;
  logic       o_a_load;
  logic       o_a_out;
  logic       o_b_load;
  logic       o_alu_out;
  logic       o_alu_sub;
  logic       o_flags_load;
  logic       o_out_load;
  logic       o_halt;

  // Datapath side: supplies enable, opcode and flags, consumes controls.
  modport master (
    output mclk_en, i_opcode, i_flag_carry, i_flag_zero,
    input  o_step, o_pc_out, o_pc_inc, o_pc_load, o_mar_load,
           o_ram_out, o_ram_load, o_ir_load, o_ir_out, o_a_load,
           o_a_out, o_b_load, o_alu_out, o_alu_sub, o_flags_load,
           o_out_load, o_halt
  );

  // Sequencer side.
  modport slave (
    input  mclk_en, i_opcode, i_flag_carry, i_flag_zero,
    output o_step, o_pc_out, o_pc_inc, o_pc_load, o_mar_load,
           o_ram_out, o_ram_load, o_ir_load, o_ir_out, o_a_load,
           o_a_out, o_b_load, o_alu_out, o_alu_sub, o_flags_load,
           o_out_load, o_halt
  );
endinterface

`default_nettype wire

// File: rtl/sap1_control_sequencer.sv
// +------------------------------------------------------------------+
// | Module   : sap1_control_sequencer                                |
// | Purpose  : SAP-1 microcoded control sequencer. Steps T0..T4      |
// |            through fetch and execute, decodes the opcode and     |
// |            drives the datapath control lines combinationally.    |
// | Options  : SAP1_EARLY_RETURN_EN - when defined, each instruction |
// |            returns to T0 right after its last active step.       |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
`default_nettype none

module sap1_control_sequencer #(
  parameter int NUM_STEPS = 5
) (
  input  wire logic                  mclk,
  input  wire logic                  reset,
  sap1_control_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  localparam logic [3:0] c_op_lda = 4'd0;
  localparam logic [3:0] c_op_add = 4'd1;
  localparam logic [3:0] c_op_sub = 4'd2;
  localparam logic [3:0] c_op_sta = 4'd3;
  localparam logic [3:0] c_op_ldi = 4'd4;
  localparam logic [3:0] c_op_jmp = 4'd5;
  localparam logic [3:0] c_op_jc  = 4'd6;
  localparam logic [3:0] c_op_jz  = 4'd7;
  localparam logic [3:0] c_op_out = 4'd14;
  localparam logic [3:0] c_op_hlt = 4'd15;

  // Final step of the full-length cycle; the counter wraps after it.
  localparam logic [2:0] c_last_step = 3'(NUM_STEPS - 1);

  step_t      r_step;
  logic       r_halt;

  logic [3:0] w_opcode;
  logic       w_hlt_t2;
  logic       w_early_last;
  logic       w_last_step;

  logic       w_pc_out;
  logic       w_pc_inc;
  logic       w_pc_load;
  logic       w_mar_load;
  logic       w_ram_out;
  logic       w_ram_load;
  logic       w_ir_load;
  logic       w_ir_out;
  logic       w_a_load;
  logic       w_a_out;
  logic       w_b_load;
  logic       w_alu_out;
  logic       w_alu_sub;
  logic       w_flags_load;
  logic       w_out_load;

  assign w_opcode = bus.i_opcode;
  assign w_hlt_t2 = (r_step == T2) && (w_opcode == c_op_hlt);

`ifdef SAP1_EARLY_RETURN_EN
  // Last active step of the current instruction; HLT never returns.
  always_comb begin
    w_early_last = 1'b0;
    case (w_opcode)
      c_op_lda, c_op_sta: w_early_last = (r_step == T3);
      c_op_add, c_op_sub: w_early_last = (r_step == T4);
      c_op_ldi, c_op_jmp, c_op_jc, c_op_jz, c_op_out:
                          w_early_last = (r_step == T2);
      c_op_hlt:           w_early_last = 1'b0;
      default:            w_early_last = (r_step == T1);
    endcase
  end
`else
  assign w_early_last = 1'b0;
`endif

  assign w_last_step = w_early_last || (r_step == step_t'(c_last_step));

  // Step counter and halt flag advance only on enabled edges.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_step <= T0;
      r_halt <= 1'b0;
    end else if (bus.mclk_en) begin
      if (r_halt) begin
        r_step <= T2;
      end else if (w_hlt_t2) begin
        r_halt <= 1'b1;
        r_step <= T2;
      end else if (w_last_step) begin
        r_step <= T0;
      end else begin
        r_step <= step_t'(r_step + 3'd1);
      end
    end
  end

  // Control word decode from step, opcode and flags; idle while halted.
  always_comb begin
    w_pc_out     = 1'b0;
    w_pc_inc     = 1'b0;
    w_pc_load    = 1'b0;
    w_mar_load   = 1'b0;
    w_ram_out    = 1'b0;
    w_ram_load   = 1'b0;
    w_ir_load    = 1'b0;
    w_ir_out     = 1'b0;
    w_a_load     = 1'b0;
    w_a_out      = 1'b0;
    w_b_load     = 1'b0;
    w_alu_out    = 1'b0;
    w_alu_sub    = 1'b0;
    w_flags_load = 1'b0;
    w_out_load   = 1'b0;
    if (!reset && !r_halt) begin
      case (r_step)
        T0: begin
          w_pc_out   = 1'b1;
          w_mar_load = 1'b1;
        end
        T1: begin
          w_ram_out = 1'b1;
          w_ir_load = 1'b1;
          w_pc_inc  = 1'b1;
        end
        T2: begin
          case (w_opcode)
            c_op_lda, c_op_add, c_op_sub, c_op_sta: begin
              w_ir_out   = 1'b1;
              w_mar_load = 1'b1;
            end
            c_op_ldi: begin
              w_ir_out = 1'b1;
              w_a_load = 1'b1;
            end
            c_op_jmp: begin
              w_ir_out  = 1'b1;
              w_pc_load = 1'b1;
            end
            c_op_jc: begin
              w_ir_out  = bus.i_flag_carry;
              w_pc_load = bus.i_flag_carry;
            end
            c_op_jz: begin
              w_ir_out  = bus.i_flag_zero;
              w_pc_load = bus.i_flag_zero;
            end
            c_op_out: begin
              w_a_out    = 1'b1;
              w_out_load = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (w_opcode)
            c_op_lda: begin
              w_ram_out = 1'b1;
              w_a_load  = 1'b1;
            end
            c_op_add, c_op_sub: begin
              w_ram_out = 1'b1;
              w_b_load  = 1'b1;
            end
            c_op_sta: begin
              w_a_out    = 1'b1;
              w_ram_load = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (w_opcode == c_op_add || w_opcode == c_op_sub) begin
            w_alu_out    = 1'b1;
            w_a_load     = 1'b1;
            w_flags_load = 1'b1;
            w_alu_sub    = (w_opcode == c_op_sub);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_step       = r_step;
  assign bus.o_pc_out     = w_pc_out;
  assign bus.o_pc_inc     = w_pc_inc;
  assign bus.o_pc_load    = w_pc_load;
  assign bus.o_mar_load   = w_mar_load;
  assign bus.o_ram_out    = w_ram_out;
  assign bus.o_ram_load   = w_ram_load;
  assign bus.o_ir_load    = w_ir_load;
  assign bus.o_ir_out     = w_ir_out;
  assign bus.o_a_load     = w_a_load;
  assign bus.o_a_out      = w_a_out;
  assign bus.o_b_load     = w_b_load;
  assign bus.o_alu_out    = w_alu_out;
  assign bus.o_alu_sub    = w_alu_sub;
  assign bus.o_flags_load = w_flags_load;
  assign bus.o_out_load   = w_out_load;
  assign bus.o_halt       = !reset && (r_halt || w_hlt_t2);

endmodule

`default_nettype wire
